// File: rtl/lc3b_mem_if_if.sv
// ---------------------------------------------------------------------------
// lc3b_mem_if_if
// Bus bundle between the LC-3b datapath/control pair, the memory-interface
// stage and the physical memory port.
//
// CPU side     : mem_read, mem_write, mem_byte, mem_address, mem_wdata  (to stage)
//                mem_resp, mem_rdata, mem_err                           (from stage)
// Physical side: pmem_read, pmem_write, pmem_address, pmem_wdata,
//                pmem_wmask                                             (from stage)
//                pmem_resp, pmem_rdata                                  (to stage)
//
// slave  : view of the memory-interface stage itself
// master : view of the surrounding environment (CPU plus physical memory)
// ---------------------------------------------------------------------------
interface lc3b_mem_if_if;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_err;

    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_wmask;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    modport slave (
        input  mem_read, mem_write, mem_byte, mem_address, mem_wdata,
        input  pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata, mem_err,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );

    modport master (
        output mem_read, mem_write, mem_byte, mem_address, mem_wdata,
        output pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata, mem_err,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );
endinterface

// File: rtl/lc3b_mem_if.sv
// ---------------------------------------------------------------------------
// lc3b_mem_if
// Registered memory-interface stage for the LC-3b. Captures one CPU memory
// request, drives the physical memory port with a held strobe until
// pmem_resp (or a watchdog timeout), then returns a one-cycle mem_resp with
// mem_err. Handles STB byte-lane steering and flags misaligned word accesses
// without touching physical memory. Every output comes straight from a flop.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - lc3b_mem_if_if.slave (CPU request/response + physical port)
//
// Parameters:
//   TIMEOUT - max cycles spent strobing without pmem_resp (1..65535)
// ---------------------------------------------------------------------------
module lc3b_mem_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    lc3b_mem_if_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter starts at 0 in the first strobe cycle, so the last allowed
    // cycle is TIMEOUT-1; this gives exactly TIMEOUT strobe cycles.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] wait_cnt, wait_cnt_next;

    logic        mem_resp_q,     mem_resp_d;
    logic [15:0] mem_rdata_q,    mem_rdata_d;
    logic        mem_err_q,      mem_err_d;
    logic        pmem_read_q,    pmem_read_d;
    logic        pmem_write_q,   pmem_write_d;
    logic [15:0] pmem_address_q, pmem_address_d;
    logic [15:0] pmem_wdata_q,   pmem_wdata_d;
    logic [1:0]  pmem_wmask_q,   pmem_wmask_d;

    logic        req_valid;
    logic        req_write;
    logic        misaligned;

    // A simultaneous read+write is treated as a write.
    assign req_valid  = bus.mem_read | bus.mem_write;
    assign req_write  = bus.mem_write;
    assign misaligned = ~bus.mem_byte & bus.mem_address[0];

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        mem_resp_d     = 1'b0;
        mem_err_d      = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        pmem_wmask_d   = pmem_wmask_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        // Rejected without any physical access.
                        state_next = DONE;
                        mem_resp_d = 1'b1;
                        mem_err_d  = 1'b1;
                    end else begin
                        state_next     = BUSY;
                        wait_cnt_next  = 16'd0;
                        pmem_read_d    = ~req_write;
                        pmem_write_d   = req_write;
                        pmem_address_d = {bus.mem_address[15:1], 1'b0};
                        // Byte stores replicate the low byte on both lanes;
                        // the mask picks the lane that memory actually writes.
                        if (bus.mem_byte) begin
                            pmem_wdata_d = {bus.mem_wdata[7:0], bus.mem_wdata[7:0]};
                        end else begin
                            pmem_wdata_d = bus.mem_wdata;
                        end
                        if (!req_write) begin
                            pmem_wmask_d = 2'b00;
                        end else if (!bus.mem_byte) begin
                            pmem_wmask_d = 2'b11;
                        end else if (bus.mem_address[0]) begin
                            pmem_wmask_d = 2'b10;
                        end else begin
                            pmem_wmask_d = 2'b01;
                        end
                    end
                end
            end

            BUSY: begin
                // pmem_resp takes priority over a timeout on the same edge.
                if (bus.pmem_resp) begin
                    state_next   = DONE;
                    mem_resp_d   = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (pmem_read_q) begin
                        mem_rdata_d = bus.pmem_rdata;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_next   = DONE;
                    mem_resp_d   = 1'b1;
                    mem_err_d    = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (pmem_read_q) begin
                        mem_rdata_d = 16'h0000;
                    end
                end else begin
                    wait_cnt_next = wait_cnt + 16'd1;
                end
            end

            DONE: begin
                // Requests seen here are ignored; the IDLE cycle that follows
                // picks up anything still being held.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= 16'd0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= 16'h0000;
            mem_err_q      <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 16'h0000;
            pmem_wdata_q   <= 16'h0000;
            pmem_wmask_q   <= 2'b00;
        end else begin
            state          <= state_next;
            wait_cnt       <= wait_cnt_next;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_err_q      <= mem_err_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            pmem_wmask_q   <= pmem_wmask_d;
        end
    end

    assign bus.mem_resp     = mem_resp_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.mem_err      = mem_err_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.pmem_wmask   = pmem_wmask_q;

endmodule

// File: tb/tb_lc3b_mem_if.sv
// ---------------------------------------------------------------------------
// tb_lc3b_mem_if
// Self-checking bench for lc3b_mem_if built with TIMEOUT=4. A table of
// directed transactions (hand-computed expectations) is played through a
// small CPU/memory driver; reset-during-BUSY and back-to-back requests are
// written out cycle by cycle.
// ---------------------------------------------------------------------------
module tb_lc3b_mem_if;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lc3b_mem_if_if bus();

    lc3b_mem_if #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] prdata;
        int          resp_at;      // strobe cycle in which memory answers (0 = never)
        int          exp_strobes;
        logic        exp_wr;
        logic [15:0] exp_paddr;
        logic [15:0] exp_pwdata;
        logic [1:0]  exp_wmask;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_byte    = 1'b0;
        bus.mem_address = 16'h0000;
        bus.mem_wdata   = 16'h0000;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = 16'h0000;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          strobes  = 0;
        int          latency  = 0;
        logic        done     = 1'b0;
        logic        seen_wr  = 1'b0;
        logic        err_seen = 1'b0;
        logic [15:0] rdata_seen = 16'h0000;
        logic [15:0] paddr    = 16'h0000;
        logic [15:0] pwdata   = 16'h0000;
        logic [1:0]  wmask    = 2'b00;

        bus.mem_read    = v.rd;
        bus.mem_write   = v.wr;
        bus.mem_byte    = v.byt;
        bus.mem_address = v.addr;
        bus.mem_wdata   = v.wdata;
        bus.pmem_rdata  = v.prdata;
        bus.pmem_resp   = 1'b0;
        @(posedge clk);

        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read || bus.pmem_write) begin
                strobes++;
                if (strobes == 1) begin
                    seen_wr = bus.pmem_write;
                    paddr   = bus.pmem_address;
                    pwdata  = bus.pmem_wdata;
                    wmask   = bus.pmem_wmask;
                end
                if (strobes == v.resp_at) begin
                    bus.pmem_resp = 1'b1;
                end
            end
            if (bus.mem_resp) begin
                done       = 1'b1;
                latency    = cyc;
                err_seen   = bus.mem_err;
                rdata_seen = bus.mem_rdata;
            end
        end

        checkOutput($sformatf("v%0d mem_resp seen", idx), 32'(done), 32'd1);
        checkOutput($sformatf("v%0d strobe cycles", idx), strobes, v.exp_strobes);
        checkOutput($sformatf("v%0d latency", idx), latency, v.exp_strobes + 1);
        checkOutput($sformatf("v%0d mem_err", idx), 32'(err_seen), 32'(v.exp_err));
        checkOutput($sformatf("v%0d mem_rdata", idx), 32'(rdata_seen), 32'(v.exp_rdata));
        if (v.exp_strobes != 0) begin
            checkOutput($sformatf("v%0d direction", idx), 32'(seen_wr), 32'(v.exp_wr));
            checkOutput($sformatf("v%0d pmem_address", idx), 32'(paddr), 32'(v.exp_paddr));
            checkOutput($sformatf("v%0d pmem_wmask", idx), 32'(wmask), 32'(v.exp_wmask));
            if (v.exp_wr) begin
                checkOutput($sformatf("v%0d pmem_wdata", idx), 32'(pwdata), 32'(v.exp_pwdata));
            end
        end

        idleInputs();
        @(negedge clk);
        checkOutput($sformatf("v%0d single pulse", idx), 32'(bus.mem_resp), 32'd0);
        checkOutput($sformatf("v%0d strobes dropped", idx),
                    32'(bus.pmem_read | bus.pmem_write), 32'd0);
    endtask

    initial begin
        logic stayed_quiet;

        vecs[0] = '{rd:1, wr:0, byt:0, addr:16'h3000, wdata:16'h0000, prdata:16'hBEEF,
                    resp_at:3, exp_strobes:3, exp_wr:0, exp_paddr:16'h3000,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:0, exp_rdata:16'hBEEF};
        vecs[1] = '{rd:0, wr:1, byt:1, addr:16'h4001, wdata:16'h12A5, prdata:16'h1111,
                    resp_at:1, exp_strobes:1, exp_wr:1, exp_paddr:16'h4000,
                    exp_pwdata:16'hA5A5, exp_wmask:2'b10, exp_err:0, exp_rdata:16'hBEEF};
        vecs[2] = '{rd:0, wr:1, byt:1, addr:16'h4000, wdata:16'h12A5, prdata:16'h1111,
                    resp_at:2, exp_strobes:2, exp_wr:1, exp_paddr:16'h4000,
                    exp_pwdata:16'hA5A5, exp_wmask:2'b01, exp_err:0, exp_rdata:16'hBEEF};
        vecs[3] = '{rd:0, wr:1, byt:0, addr:16'h5003, wdata:16'h9999, prdata:16'h1111,
                    resp_at:1, exp_strobes:0, exp_wr:0, exp_paddr:16'h0000,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:1, exp_rdata:16'hBEEF};
        vecs[4] = '{rd:1, wr:0, byt:0, addr:16'h6000, wdata:16'h0000, prdata:16'hDEAD,
                    resp_at:0, exp_strobes:4, exp_wr:0, exp_paddr:16'h6000,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:1, exp_rdata:16'h0000};
        vecs[5] = '{rd:1, wr:0, byt:0, addr:16'h6002, wdata:16'h0000, prdata:16'hCAFE,
                    resp_at:4, exp_strobes:4, exp_wr:0, exp_paddr:16'h6002,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:0, exp_rdata:16'hCAFE};
        vecs[6] = '{rd:1, wr:1, byt:0, addr:16'h7000, wdata:16'h1234, prdata:16'h1111,
                    resp_at:2, exp_strobes:2, exp_wr:1, exp_paddr:16'h7000,
                    exp_pwdata:16'h1234, exp_wmask:2'b11, exp_err:0, exp_rdata:16'hCAFE};
        vecs[7] = '{rd:1, wr:0, byt:1, addr:16'h8001, wdata:16'h0000, prdata:16'h5A3C,
                    resp_at:1, exp_strobes:1, exp_wr:0, exp_paddr:16'h8000,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:0, exp_rdata:16'h5A3C};
        vecs[8] = '{rd:1, wr:0, byt:0, addr:16'h9001, wdata:16'h0000, prdata:16'h7777,
                    resp_at:1, exp_strobes:0, exp_wr:0, exp_paddr:16'h0000,
                    exp_pwdata:16'h0000, exp_wmask:2'b00, exp_err:1, exp_rdata:16'h5A3C};
        vecs[9] = '{rd:0, wr:1, byt:0, addr:16'hA000, wdata:16'hFFFF, prdata:16'h1111,
                    resp_at:0, exp_strobes:4, exp_wr:1, exp_paddr:16'hA000,
                    exp_pwdata:16'hFFFF, exp_wmask:2'b11, exp_err:1, exp_rdata:16'h5A3C};

        idleInputs();
        #23;
        checkOutput("reset mem_resp",  32'(bus.mem_resp),  32'd0);
        checkOutput("reset mem_err",   32'(bus.mem_err),   32'd0);
        checkOutput("reset mem_rdata", 32'(bus.mem_rdata), 32'd0);
        checkOutput("reset strobes",   32'(bus.pmem_read | bus.pmem_write), 32'd0);
        checkOutput("reset pmem_address", 32'(bus.pmem_address), 32'd0);
        checkOutput("reset pmem_wmask",   32'(bus.pmem_wmask),   32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset asserted while a read is being strobed.
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset pmem_read", 32'(bus.pmem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pmem_read",    32'(bus.pmem_read),    32'd0);
        checkOutput("async reset pmem_address", 32'(bus.pmem_address), 32'd0);
        checkOutput("async reset mem_rdata",    32'(bus.mem_rdata),    32'd0);
        checkOutput("async reset mem_resp",     32'(bus.mem_resp),     32'd0);
        idleInputs();
        @(negedge clk);
        rst_n = 1'b1;
        stayed_quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.mem_resp || bus.pmem_read || bus.pmem_write) begin
                stayed_quiet = 1'b0;
            end
        end
        checkOutput("no retry after reset", 32'(stayed_quiet), 32'd1);

        // Request held through DONE: one IDLE gap, then a fresh transaction.
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b first strobe", 32'(bus.pmem_read), 32'd1);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1357;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        checkOutput("b2b first mem_resp", 32'(bus.mem_resp),  32'd1);
        checkOutput("b2b first rdata",    32'(bus.mem_rdata), 32'h1357);
        @(negedge clk);
        checkOutput("b2b idle gap resp",   32'(bus.mem_resp),  32'd0);
        checkOutput("b2b idle gap strobe", 32'(bus.pmem_read), 32'd0);
        @(negedge clk);
        checkOutput("b2b second strobe", 32'(bus.pmem_read), 32'd1);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h2468;
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        checkOutput("b2b second mem_resp", 32'(bus.mem_resp),  32'd1);
        checkOutput("b2b second rdata",    32'(bus.mem_rdata), 32'h2468);
        idleInputs();
        @(negedge clk);
        checkOutput("b2b final idle", 32'(bus.mem_resp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lc3b_mem_if.md
Name: lc3b_mem_if

Overview:
- Registered memory-interface stage directly downstream of the LC-3b datapath/control pair.
- Captures one CPU memory request (mem_address, mem_wdata, mem_read/mem_write, byte flag) and drives a physical memory port with a registered req/resp handshake.
- Returns read data and a single-cycle mem_resp.
- Adds byte-lane steering for STB, a misalignment check and a watchdog timeout.

Parameters:
TIMEOUT, 255, max cycles in BUSY awaiting pmem_resp before forced error completion (legal 1..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  CPU read request, held until mem_resp seen
mem_write  in  1  CPU write request, held until mem_resp seen
mem_byte  in  1  1 = byte access (LDB/STB), 0 = word access
mem_address  in  16  byte address from MAR
mem_wdata  in  16  write data from MDR
mem_resp  out  1  one-cycle completion pulse to control
mem_rdata  out  16  read data (raw 16-bit word), held until next read completes
mem_err  out  1  valid with mem_resp: 1 = misaligned or timeout
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_address  out  16  word-aligned address {mem_address[15:1],1'b0}
pmem_wdata  out  16  steered write data
pmem_wmask  out  2  byte enables, bit0 = low byte
pmem_resp  in  1  physical completion, one cycle
pmem_rdata  in  16  physical read data, valid with pmem_resp

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; wait counter 0. Reset mid-transaction drops pmem_read/pmem_write at once. No retry after reset.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, BUSY, DONE.
- IDLE, on edge with mem_read|mem_write:
  - Capture address/data/byte/direction.
  - If mem_write and mem_read are both high, write wins (no error).
  - Word access with mem_address[0]=1: misaligned. Go to DONE with mem_err=1, no pmem strobe, mem_rdata unchanged.
  - Otherwise go to BUSY, assert pmem_read or pmem_write from the next cycle, counter=0.
- Write steering:
  - Word: pmem_wdata=mem_wdata, wmask=2'b11.
  - Byte, addr[0]=0: pmem_wdata={wdata[7:0],wdata[7:0]}, wmask=2'b01.
  - Byte, addr[0]=1: same data, wmask=2'b10.
  - Reads: wmask=2'b00.
- BUSY: strobe and address/data held stable. Counter increments each cycle pmem_resp=0.
  - pmem_resp=1: drop strobe, go to DONE with mem_err=0. On reads, also latch mem_rdata<=pmem_rdata.
  - Counter reaches TIMEOUT-1 without pmem_resp: drop strobe, go to DONE with mem_err=1, mem_rdata<=16'h0000 on reads.
  - pmem_resp on the same edge as timeout: pmem_resp wins, no error.
- DONE: mem_resp=1 for exactly one cycle, mem_err valid. Next state is always IDLE; any request seen while in DONE is ignored.
- One-cycle IDLE gap between transactions. A request still held in IDLE is treated as new.
- Latency: request seen at edge N; pmem strobe high from N+1; pmem_resp at cycle N+1+k; mem_resp high in cycle N+2+k. Misaligned: mem_resp in cycle N+1.
- pmem_resp while IDLE/DONE is ignored. Inputs may change freely outside the IDLE capture edge.
- Byte reads return the full word; byte selection is done by the datapath mask logic.

Test Plan:
- Reset assert during BUSY read (pmem_read=1) -> pmem_read and all outputs 0 immediately; after release, state IDLE, mem_resp stays 0.
- Word read 0x3000, pmem_resp after 3 cycles with rdata 0xBEEF -> pmem_address 0x3000, pmem_read high 3 cycles, one mem_resp pulse, mem_rdata=0xBEEF, mem_err=0.
- STB address 0x4001, wdata 0x12A5 -> pmem_address 0x4000, pmem_wdata 0xA5A5, wmask 2'b10. With address 0x4000 -> wmask 2'b01.
- Word write to 0x5003 -> no pmem strobe, mem_resp+mem_err one cycle after capture, mem_rdata unchanged.
- TIMEOUT=4, read with no pmem_resp -> pmem_read high exactly 4 cycles, then mem_resp=1, mem_err=1, mem_rdata=0x0000. Repeat with pmem_resp on 4th cycle -> mem_err=0.
- Back-to-back: mem_read held through DONE -> exactly one IDLE cycle, then second transaction. Simultaneous read+write -> write performed, wmask 2'b11.
